// File: rtl/mtime_timer_if.sv
// Register bus for mtime_timer: single-cycle request strobe, registered ack
// one cycle later with read data. No back-pressure.
interface mtime_timer_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid_i;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              ack_o;
    logic [31:0]       rdata_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  ack_o, rdata_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output ack_o, rdata_o
    );
endinterface

// File: rtl/mtime_timer.sv
// mtime_timer: synchronizes the real-time tick square wave into clk_sys_i,
// advances a 64-bit mtime, holds mtime/mtimecmp behind a small register bus
// and raises MTIP when mtime >= mtimecmp.
// Optional feature macro: MTIME_MSIP_EN (adds msip register at 0x10 and msip_o).
module mtime_timer #(
    parameter int ADDR_W  = 5,
    parameter int SYNC_FF = 2
) (
    input  logic          clk_sys_i,
    input  logic          rst_n_i,
    input  logic          clk_real_time_i,
    mtime_timer_if.slave  bus,
    output logic          mtip_o
`ifdef MTIME_MSIP_EN
    ,
    output logic          msip_o
`endif
);
    localparam logic [ADDR_W-1:0] A_TIME_LO = ADDR_W'(5'h00);
    localparam logic [ADDR_W-1:0] A_TIME_HI = ADDR_W'(5'h04);
    localparam logic [ADDR_W-1:0] A_CMP_LO  = ADDR_W'(5'h08);
    localparam logic [ADDR_W-1:0] A_CMP_HI  = ADDR_W'(5'h0C);
`ifdef MTIME_MSIP_EN
    localparam logic [ADDR_W-1:0] A_MSIP    = ADDR_W'(5'h10);
`endif

    logic [SYNC_FF-1:0] sync_q;
    logic               hist_q;
    logic               tick;
    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;
    logic               mtip_q, mtip_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        rd_val;
    logic               wr;
`ifdef MTIME_MSIP_EN
    logic               msip_q, msip_d;
`endif

    // Synchronizer chain plus history flop; the rising edge becomes a one-cycle tick.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_FF-2:0], clk_real_time_i};
            hist_q <= sync_q[SYNC_FF-1];
        end
    end

    assign tick = sync_q[SYNC_FF-1] & ~hist_q;
    assign wr   = bus.req_valid_i & bus.req_we_i;

    // Read mux on current register values; unmapped offsets read zero.
    always_comb begin
        rd_val = 32'h0;
        case (bus.req_addr_i)
            A_TIME_LO: rd_val = mtime_q[31:0];
            A_TIME_HI: rd_val = mtime_q[63:32];
            A_CMP_LO:  rd_val = mtimecmp_q[31:0];
            A_CMP_HI:  rd_val = mtimecmp_q[63:32];
`ifdef MTIME_MSIP_EN
            A_MSIP:    rd_val = {31'h0, msip_q};
`endif
            default:   rd_val = 32'h0;
        endcase
    end

    // Next-state: a write to either mtime half overrides (and swallows) a same-cycle tick.
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
`ifdef MTIME_MSIP_EN
        msip_d     = msip_q;
`endif
        if (wr) begin
            case (bus.req_addr_i)
                A_TIME_LO: mtime_d = {mtime_q[63:32], bus.req_wdata_i};
                A_TIME_HI: mtime_d = {bus.req_wdata_i, mtime_q[31:0]};
                A_CMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], bus.req_wdata_i};
                A_CMP_HI:  mtimecmp_d = {bus.req_wdata_i, mtimecmp_q[31:0]};
`ifdef MTIME_MSIP_EN
                A_MSIP:    msip_d = bus.req_wdata_i[0];
`endif
                default:   ;
            endcase
        end
        mtip_d  = (mtime_d >= mtimecmp_d);
        ack_d   = bus.req_valid_i;
        rdata_d = bus.req_valid_i ? rd_val : 32'h0;
    end

    // Architectural registers and registered bus response.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtip_q     <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'h0;
`ifdef MTIME_MSIP_EN
            msip_q     <= 1'b0;
`endif
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtip_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
`ifdef MTIME_MSIP_EN
            msip_q     <= msip_d;
`endif
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.rdata_o = rdata_q;
    assign mtip_o      = mtip_q;
`ifdef MTIME_MSIP_EN
    assign msip_o      = msip_q;
`endif
endmodule
